// File: rtl/turbo_itl_buffer.sv
// turbo_itl_buffer: two-bank ping-pong bit buffer for the turbo encoder front end.
// Serial bits are collected into BLK_LEN-bit blocks, each tagged with the link_id
// seen on its first bit. A request streams the oldest full block out in natural
// order and, in parallel, in QPP-interleaved order pi(i) = (F1*i + F2*i^2) mod K.
// The QPP address uses two running sums, so no multipliers are needed.
module turbo_itl_buffer #(
  parameter int BLK_LEN = 40,
  parameter int F1      = 3,
  parameter int F2      = 10,
  parameter int ID_W    = 6
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [ID_W-1:0] link_id,
  input  logic            din,
  input  logic            din_vld,
  output logic            din_ready,
  input  logic            request,
  output logic            rdata,
  output logic            rdata_itl,
  output logic            rd_vld,
  output logic            rd_last,
  output logic [ID_W-1:0] rd_id,
  output logic            ovf
);

  localparam int AW     = $clog2(BLK_LEN);
  localparam int D_INT  = (2 * F2) % BLK_LEN;
  localparam int G0_INT = (F1 + F2) % BLK_LEN;

  localparam logic [AW:0]   K_C    = (AW+1)'(BLK_LEN);
  localparam logic [AW:0]   D_C    = (AW+1)'(D_INT);
  localparam logic [AW:0]   G0_C   = (AW+1)'(G0_INT);
  localparam logic [AW-1:0] LAST_C = AW'(BLK_LEN - 1);

  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_e;
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_READ} rd_state_e;

  // Bank bookkeeping and write side
  bank_e           r_bank [2];
  logic [ID_W-1:0] r_id   [2];
  logic [BLK_LEN-1:0] r_mem [2];
  logic            r_wb;
  logic            r_rb;
  logic [AW-1:0]   r_wr_cnt;
  logic            r_run;
  logic            r_ovf;

  // Read side
  rd_state_e       r_state;
  rd_state_e       w_state_nxt;
  logic [AW-1:0]   r_i;
  logic [AW:0]     r_pi;
  logic [AW:0]     r_g;
  logic            r_rdata;
  logic            r_rdata_itl;
  logic            r_rd_vld;
  logic            r_rd_last;
  logic [ID_W-1:0] r_rd_id;

  logic            w_din_ready;
  logic            w_wr;
  logic            w_accept;
  logic            w_rd_done;
  logic [AW:0]     w_pi_sum;
  logic [AW:0]     w_pi_nxt;
  logic [AW:0]     w_g_sum;
  logic [AW:0]     w_g_nxt;
  logic [AW-1:0]   w_pi_idx;

  // r_run keeps din_ready low for the first cycle after reset release.
  assign w_din_ready = r_run && (r_bank[r_wb] != BANK_FULL);
  assign w_wr        = din_vld && w_din_ready;
  assign w_accept    = (r_state == S_IDLE) && request && (r_bank[r_rb] == BANK_FULL);
  assign w_rd_done   = (r_state == S_READ) && (r_i == LAST_C);

  // QPP recurrences: both operands are below K, so one conditional subtract is a full mod.
  assign w_pi_sum = r_pi + r_g;
  assign w_pi_nxt = (w_pi_sum >= K_C) ? (w_pi_sum - K_C) : w_pi_sum;
  assign w_g_sum  = r_g + D_C;
  assign w_g_nxt  = (w_g_sum >= K_C) ? (w_g_sum - K_C) : w_g_sum;
  assign w_pi_idx = r_pi[AW-1:0];

  // Write pointer, block tags, bank states, overflow flag and bank release after a burst.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bank[0] <= BANK_EMPTY;
      r_bank[1] <= BANK_EMPTY;
      r_id[0]   <= '0;
      r_id[1]   <= '0;
      r_wb      <= 1'b0;
      r_rb      <= 1'b0;
      r_wr_cnt  <= '0;
      r_run     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every always_ff samples
      // pre-edge values; blocking here would make results depend on block ordering.
      r_run <= 1'b1;
      if (w_wr) begin
        if (r_wr_cnt == '0) begin
          r_id[r_wb] <= link_id;
        end
        if (r_wr_cnt == LAST_C) begin
          r_bank[r_wb] <= BANK_FULL;
          r_wr_cnt     <= '0;
          r_wb         <= ~r_wb;
        end else begin
          r_bank[r_wb] <= BANK_FILLING;
          r_wr_cnt     <= r_wr_cnt + 1'b1;
        end
      end
      if (din_vld && !w_din_ready) begin
        r_ovf <= 1'b1;
      end
      // The bank being read is FULL, so it is never the write target this cycle.
      if (w_rd_done) begin
        r_bank[r_rb] <= BANK_EMPTY;
        r_rb         <= ~r_rb;
      end
    end
  end

  // Bit storage for both banks.
  // NOTE: the memory has no reset; its contents are only read after being written,
  // and leaving it out of reset lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wb][r_wr_cnt] <= din;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read FSM next state; requests outside IDLE or without a full bank are dropped.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_PRIME;
      S_PRIME: w_state_nxt = S_READ;
      S_READ:  if (w_rd_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address generators and registered output stream.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_i         <= '0;
      r_pi        <= '0;
      r_g         <= '0;
      r_rdata     <= 1'b0;
      r_rdata_itl <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_id     <= '0;
    end else begin
      if (r_state == S_PRIME) begin
        r_i  <= '0;
        r_pi <= '0;
        r_g  <= G0_C;
      end else if (r_state == S_READ) begin
        r_i  <= r_i + 1'b1;
        r_pi <= w_pi_nxt;
        r_g  <= w_g_nxt;
      end
      if (r_state == S_READ) begin
        r_rdata     <= r_mem[r_rb][r_i];
        r_rdata_itl <= r_mem[r_rb][w_pi_idx];
        r_rd_vld    <= 1'b1;
        r_rd_last   <= (r_i == LAST_C);
        r_rd_id     <= r_id[r_rb];
      end else begin
        r_rdata     <= 1'b0;
        r_rdata_itl <= 1'b0;
        r_rd_vld    <= 1'b0;
        r_rd_last   <= 1'b0;
        r_rd_id     <= '0;
      end
    end
  end

  assign din_ready = w_din_ready;
  assign rdata     = r_rdata;
  assign rdata_itl = r_rdata_itl;
  assign rd_vld    = r_rd_vld;
  assign rd_last   = r_rd_last;
  assign rd_id     = r_rd_id;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_turbo_itl_buffer.sv
// Bench for turbo_itl_buffer: directed scenarios plus a randomized phase, all checked
// every cycle against a block-level model (queue of full blocks, QPP by formula).
module tb_turbo_itl_buffer;

  localparam int BLK_LEN = 40;
  localparam int F1      = 3;
  localparam int F2      = 10;
  localparam int ID_W    = 6;

  logic            clk;
  logic            n_rst;
  logic [ID_W-1:0] link_id;
  logic            din;
  logic            din_vld;
  logic            din_ready;
  logic            request;
  logic            rdata;
  logic            rdata_itl;
  logic            rd_vld;
  logic            rd_last;
  logic [ID_W-1:0] rd_id;
  logic            ovf;

  turbo_itl_buffer #(
    .BLK_LEN(BLK_LEN), .F1(F1), .F2(F2), .ID_W(ID_W)
  ) dut (
    .clk(clk), .n_rst(n_rst), .link_id(link_id), .din(din), .din_vld(din_vld),
    .din_ready(din_ready), .request(request), .rdata(rdata), .rdata_itl(rdata_itl),
    .rd_vld(rd_vld), .rd_last(rd_last), .rd_id(rd_id), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BLK_LEN-1:0] bits;
    logic [ID_W-1:0]    id;
  } blk_t;

  typedef struct {
    bit              d;
    bit              itl;
    bit              last;
    logic [ID_W-1:0] id;
  } out_t;

  typedef struct {
    int              n_vld;
    int              lat;
    int              d_idx;
    int              d_ones;
    int              itl_idx;
    int              itl_ones;
    int              last_idx;
    logic [ID_W-1:0] id;
  } burst_t;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: stored full blocks (oldest first), block being collected, and the
  // expected output per clock-edge number.
  blk_t full_q[$];
  blk_t m_part;
  int   m_cnt;
  bit   m_run;
  bit   m_ovf;
  int   cyc = 0;
  int   busy_until;
  out_t exp_out[int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, cyc);
  endtask

  function automatic int qpp(input int i);
    longint v;
    v = (longint'(F1) * i + longint'(F2) * i * i) % BLK_LEN;
    return int'(v);
  endfunction

  function automatic void model_reset();
    full_q.delete();
    exp_out.delete();
    m_part     = '{default: '0};
    m_cnt      = 0;
    m_run      = 1'b0;
    m_ovf      = 1'b0;
    busy_until = -1;
  endfunction

  // One clock edge of the model, using the inputs presented before that edge.
  function automatic void model_edge(input bit vld, input bit d, input logic [ID_W-1:0] id,
                                     input bit req);
    bit   wr_ok;
    blk_t b;
    wr_ok = m_run && (full_q.size() < 2);
    cyc++;
    if (req && (cyc > busy_until) && (full_q.size() >= 1)) begin
      b = full_q[0];
      for (int i = 0; i < BLK_LEN; i++)
        exp_out[cyc + 2 + i] = '{b.bits[i], b.bits[qpp(i)], (i == BLK_LEN - 1), b.id};
      busy_until = cyc + BLK_LEN + 1;
    end else if (cyc == busy_until) begin
      void'(full_q.pop_front());
    end
    if (vld) begin
      if (wr_ok) begin
        if (m_cnt == 0) m_part.id = id;
        m_part.bits[m_cnt] = d;
        m_cnt++;
        if (m_cnt == BLK_LEN) begin
          full_q.push_back(m_part);
          m_cnt = 0;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_run = 1'b1;
  endfunction

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    out_t r;
    bit   v;
    v = exp_out.exists(cyc) != 0;
    check("din_ready", din_ready, m_run && (full_q.size() < 2));
    check("ovf", ovf, m_ovf);
    check("rd_vld", rd_vld, v);
    if (v) begin
      r = exp_out[cyc];
      check("rdata", rdata, r.d);
      check("rdata_itl", rdata_itl, r.itl);
      check("rd_last", rd_last, r.last);
      check("rd_id", rd_id, r.id);
    end else begin
      check("rd_last_idle", rd_last, 1'b0);
    end
  end

  // Drive one cycle at negedge+1, model the coming edge, return at the next negedge+1.
  task automatic cycle(input bit vld, input bit d, input logic [ID_W-1:0] id, input bit req);
    din_vld = vld;
    din     = d;
    link_id = id;
    request = req;
    model_edge(vld, d, id, req);
    @(negedge clk);
    #1;
  endtask

  task automatic write_block(input logic [BLK_LEN-1:0] bits, input logic [ID_W-1:0] id,
                             input bit req_last);
    for (int i = 0; i < BLK_LEN; i++)
      cycle(1'b1, bits[i], id, req_last && (i == BLK_LEN - 1));
  endtask

  function automatic logic [BLK_LEN-1:0] rnd_bits();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[BLK_LEN-1:0];
  endfunction

  // Request pulse, then watch the burst; optionally pulse request again mid-burst and/or
  // write a full new block concurrently.
  task automatic read_burst(input bit mid_pulse, input bit do_write, input logic [ID_W-1:0] wid,
                            output burst_t st);
    int wcnt;
    bit vld;
    bit req;
    wcnt = 0;
    st   = '{n_vld: 0, lat: -1, d_idx: -1, d_ones: 0, itl_idx: -1, itl_ones: 0,
             last_idx: -1, id: '0};
    for (int c = 0; c < BLK_LEN + 12; c++) begin
      req = (c == 0) || (mid_pulse && (st.n_vld == 5));
      vld = do_write && (wcnt < BLK_LEN);
      cycle(vld, 1'($urandom_range(0, 1)), wid, req);
      if (vld) wcnt++;
      if (rd_vld) begin
        if (st.lat < 0) st.lat = c;
        if (rdata) begin
          st.d_ones++;
          if (st.d_idx < 0) st.d_idx = st.n_vld;
        end
        if (rdata_itl) begin
          st.itl_ones++;
          if (st.itl_idx < 0) st.itl_idx = st.n_vld;
        end
        if (rd_last) st.last_idx = st.n_vld;
        st.id = rd_id;
        st.n_vld++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_vld"}, rd_vld, 1'b0);
    check({tag, "_rdata"}, rdata, 1'b0);
    check({tag, "_rdata_itl"}, rdata_itl, 1'b0);
    check({tag, "_rd_last"}, rd_last, 1'b0);
    check({tag, "_rd_id"}, rd_id, '0);
    check({tag, "_ovf"}, ovf, 1'b0);
    check({tag, "_din_ready"}, din_ready, 1'b0);
  endtask

  task automatic idle_requests(input string tag);
    int nv;
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, 1'b0, '0, (c % 2) == 0);
      if (rd_vld) nv++;
    end
    check(tag, nv, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    burst_t             st;
    logic [BLK_LEN-1:0] b;
    int                 seen;
    bit                 hit;
    bit                 v;

    n_rst   = 1'b1;
    din     = 1'b0;
    din_vld = 1'b0;
    link_id = '0;
    request = 1'b0;
    model_reset();
    #2 n_rst = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    #1;
    n_rst = 1'b1;
    check("rdy_at_release", din_ready, 1'b0);

    // Pin the model's permutation: 0, 13, 6, 19, 12 for the default coefficients.
    check("qpp_1", qpp(1), 13);
    check("qpp_2", qpp(2), 6);
    check("qpp_3", qpp(3), 19);
    check("qpp_4", qpp(4), 12);

    cycle(1'b0, 1'b0, '0, 1'b0);
    check("rdy_after_1", din_ready, 1'b1);

    // No data: request pulses with both banks empty.
    idle_requests("nodata_vld");

    // QPP order: single 1 at bit 13; the request on the last write edge is too early.
    b     = '0;
    b[13] = 1'b1;
    write_block(b, 6'h20, 1'b1);
    read_burst(1'b0, 1'b0, '0, st);
    check("qpp_n_vld", st.n_vld, BLK_LEN);
    check("qpp_latency", st.lat, 2);
    check("qpp_d_idx", st.d_idx, 13);
    check("qpp_d_ones", st.d_ones, 1);
    check("qpp_itl_idx", st.itl_idx, 1);
    check("qpp_itl_ones", st.itl_ones, 1);
    check("qpp_last_idx", st.last_idx, BLK_LEN - 1);
    check("qpp_rd_id", st.id, 6'h20);

    // Ping-pong and overflow.
    write_block(rnd_bits(), 6'h11, 1'b0);
    write_block(rnd_bits(), 6'h2A, 1'b0);
    check("pp_rdy_full", din_ready, 1'b0);
    repeat (3) cycle(1'b1, 1'b1, 6'h3F, 1'b0);
    check("pp_ovf", ovf, 1'b1);
    read_burst(1'b1, 1'b0, '0, st);
    check("pp0_n_vld", st.n_vld, BLK_LEN);
    check("pp0_latency", st.lat, 2);
    check("pp0_rd_id", st.id, 6'h11);
    check("pp_rdy_back", din_ready, 1'b1);

    // Concurrent: block 2 written while block 1 streams.
    read_burst(1'b0, 1'b1, 6'h05, st);
    check("pp1_n_vld", st.n_vld, BLK_LEN);
    check("pp1_rd_id", st.id, 6'h2A);
    read_burst(1'b0, 1'b0, '0, st);
    check("blk2_n_vld", st.n_vld, BLK_LEN);
    check("blk2_rd_id", st.id, 6'h05);

    // Reset at output cycle 10 of an all-ones block.
    write_block('1, 6'h3C, 1'b0);
    seen = 0;
    hit  = 1'b0;
    for (int c = 0; c < BLK_LEN + 12 && !hit; c++) begin
      cycle(1'b0, 1'b0, '0, c == 0);
      if (rd_vld) begin
        if (seen == 10) hit = 1'b1;
        seen++;
      end
    end
    check("mid_reached", hit, 1'b1);
    n_rst = 1'b0;
    model_reset();
    #1 check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    #1;
    n_rst = 1'b1;
    idle_requests("post_rst_vld");
    write_block(rnd_bits(), 6'h07, 1'b0);
    read_burst(1'b0, 1'b0, '0, st);
    check("post_rst_n_vld", st.n_vld, BLK_LEN);
    check("post_rst_rd_id", st.id, 6'h07);

    // Randomized traffic: light then heavy write load, sparse requests.
    for (int c = 0; c < 900; c++) begin
      v = $urandom_range(0, 9) < ((c < 450) ? 3 : 8);
      cycle(v, 1'($urandom_range(0, 1)), ID_W'($urandom_range(0, 63)),
            $urandom_range(0, 7) == 0);
    end
    repeat (BLK_LEN + 5) cycle(1'b0, 1'b0, '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
